// File: rtl/adder_pkg.sv
// Shared helpers for the pipelined adder: stage count and parameter legality check.
package adder_pkg;

    function automatic int unsigned stages(input int unsigned width, input int unsigned chunk);
        return (chunk == 0) ? 1 : width / chunk;
    endfunction

    function automatic bit params_ok(input int unsigned width, input int unsigned chunk);
        return (chunk >= 1) && (width >= chunk) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// in_sub is present only when PIPELINED_ADDER_SUB_EN is defined.
interface pipelined_adder_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_carry;
`ifdef PIPELINED_ADDER_SUB_EN
    logic             in_sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_carry;
    logic             out_overflow;

    modport master (
        output in_valid, in_a, in_b, in_carry,
`ifdef PIPELINED_ADDER_SUB_EN
        output in_sub,
`endif
        output out_ready,
        input  in_ready, out_valid, out_sum, out_carry, out_overflow
    );

    modport slave (
        input  in_valid, in_a, in_b, in_carry,
`ifdef PIPELINED_ADDER_SUB_EN
        input  in_sub,
`endif
        input  out_ready,
        output in_ready, out_valid, out_sum, out_carry, out_overflow
    );

endinterface

// File: rtl/adder_slice.sv
// Combinational CHUNK-bit ripple adder; result is {carry_out, sum}, c_msb is the carry into
// the top bit (needed for signed overflow on the last slice).
module adder_slice #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK:0]   result,
    output logic             c_msb
);
    logic [CHUNK:0]   c;
    logic [CHUNK-1:0] s;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign result = {c[CHUNK], s};
    assign c_msb  = c[CHUNK-1];

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit adder pipelined as WIDTH/CHUNK ripple slices with a valid/ready chain per stage.
// Optional subtract (in_sub) is built when PIPELINED_ADDER_SUB_EN is defined.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input logic              clk,
    input logic              rst_n,
    pipelined_adder_if.slave io
);
    localparam int unsigned STAGES = stages(WIDTH, CHUNK);

    if (!params_ok(WIDTH, CHUNK)) begin : g_param_check
        $error("pipelined_adder: WIDTH must be a positive multiple of CHUNK");
    end

    typedef struct packed {
        logic             carry;
        logic [CHUNK-1:0] sum;
    } slice_t;

    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

`ifdef PIPELINED_ADDER_SUB_EN
    assign b_eff   = io.in_b ^ {WIDTH{io.in_sub}};
    assign cin_eff = io.in_carry ^ io.in_sub;
`else
    assign b_eff   = io.in_b;
    assign cin_eff = io.in_carry;
`endif

    // a_q[k] holds finished sum bits below (k+1)*CHUNK and untouched A bits above;
    // b_q[k] holds the remaining B bits shifted down so the next chunk sits at bit 0.
    logic [STAGES-1:0] vld_q, carry_q, vld_src, cin_src, rdy, load;
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  a_src [STAGES];
    logic [WIDTH-1:0]  b_src [STAGES];
    logic [WIDTH-1:0]  a_nxt [STAGES];
    slice_t            res   [STAGES];
    logic              c_msb [STAGES];
    logic              ovf_q;
    logic              rdy_run;

    always_comb begin
        vld_src[0] = io.in_valid;
        cin_src[0] = cin_eff;
        a_src[0]   = io.in_a;
        b_src[0]   = b_eff;
        for (int k = 1; k < STAGES; k++) begin
            vld_src[k] = vld_q[k-1];
            cin_src[k] = carry_q[k-1];
            a_src[k]   = a_q[k-1];
            b_src[k]   = b_q[k-1];
        end
    end

    // Ready ripples back from the consumer; an empty stage always accepts.
    always_comb begin
        rdy     = '0;
        load    = '0;
        rdy_run = io.out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            rdy_run = !vld_q[k] || rdy_run;
            rdy[k]  = rdy_run;
            load[k] = vld_src[k] && rdy_run;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        adder_slice #(
            .CHUNK(CHUNK)
        ) u_slice (
            .a      (a_src[k][k*CHUNK +: CHUNK]),
            .b      (b_src[k][CHUNK-1:0]),
            .cin    (cin_src[k]),
            .result (res[k]),
            .c_msb  (c_msb[k])
        );
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            a_nxt[k]                   = a_src[k];
            a_nxt[k][k*CHUNK +: CHUNK] = res[k].sum;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= '0;
            carry_q <= '0;
            ovf_q   <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (rdy[k]) begin
                    vld_q[k] <= vld_src[k];
                end
                if (load[k]) begin
                    a_q[k]     <= a_nxt[k];
                    b_q[k]     <= b_src[k] >> CHUNK;
                    carry_q[k] <= res[k].carry;
                end
            end
            if (load[STAGES-1]) begin
                ovf_q <= res[STAGES-1].carry ^ c_msb[STAGES-1];
            end
        end
    end

    assign io.in_ready     = rdy[0];
    assign io.out_valid    = vld_q[STAGES-1];
    assign io.out_sum      = a_q[STAGES-1];
    assign io.out_carry    = carry_q[STAGES-1];
    assign io.out_overflow = ovf_q;

endmodule
